// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// Frame geometry and FSM state encoding used by the top level and its bench.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO, head is presented combinationally from the register array.
// Latency: a push into an empty FIFO is visible at the head one sysclk later.
// Backpressure: push is taken when not full or when a pop happens in the same cycle; otherwise ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     sysclk,
    input  logic                     sysrst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    // When full, a simultaneous pop frees the slot being overwritten (wr_ptr == rd_ptr).
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: RXD synchroniser, 16x oversampled 8N1 framer (8E1 when UART_RX_PARITY_EN is defined), receive FIFO.
// Latency: rx_valid rises one sysclk after the stop-bit mid sample of a frame landing in an empty FIFO.
// Backpressure: rx_valid/rx_ready pops the FIFO; a byte arriving to a full FIFO with no pop is dropped and sets overrun_err.
module uart_rx_frontend
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          sysrst,
    input  logic                          RXD,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_err,
    output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clr
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [SW-1:0] MID      = SW'(MID_SAMPLE);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxd_m;
    logic                 rxd_s;
    logic [15:0]          tick_cnt;
    logic                 tick;
    logic [SW-1:0]        scnt;
    logic                 mid;
    rx_state_t            state;
    rx_state_t            nxt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 go_start;
    logic                 push;
    logic                 frame_set;
    logic                 overrun_set;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                 par_set;
    logic                 par_bad;
`endif

    assign tick        = (tick_cnt == DIV_LAST);
    assign mid         = tick && (scnt == MID);
    assign rx_valid    = !fifo_empty;
    assign pop         = rx_valid && rx_ready;
    assign overrun_set = push && fifo_full && !pop;

    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= RXD;
            rxd_s <= rxd_m;
        end
    end

    // Restarting the divider on the start edge puts every mid sample a fixed distance from it.
    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            tick_cnt <= '0;
            scnt     <= '0;
        end else begin
            if (go_start || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (go_start) begin
                scnt <= '0;
            end else if (tick && state != IDLE) begin
                scnt <= scnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        go_start  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    nxt      = START;
                    go_start = 1'b1;
                end
            end
            START: begin
                if (mid) begin
                    nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    nxt = PARITY;
`else
                    nxt = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (mid) begin
                    nxt     = STOP;
                    par_set = ^{shreg, rxd_s};
                end
`else
                nxt = IDLE;
`endif
            end
            STOP: begin
                if (mid) begin
                    if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad;
`else
                        push = 1'b1;
`endif
                        nxt  = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        nxt       = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (mid) begin
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // Error flags: a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set   || (frame_err   && !err_clr);
            overrun_err <= overrun_set || (overrun_err && !err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk) begin
        if (!sysrst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (go_start) begin
                par_bad <= 1'b0;
            end else if (state == PARITY && mid) begin
                par_bad <= par_set;
            end
            parity_err <= par_set || (parity_err && !err_clr);
        end
    end
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .sysclk   (sysclk),
        .sysrst   (sysrst),
        .push     (push),
        .push_dat (shreg),
        .pop      (pop),
        .head_dat (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (rx_level)
    );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: directed 8N1 frames at CLK_DIV=4 (64 sysclk/bit), FIFO_DEPTH=4.
// Expected bytes go into a queue; a negedge monitor compares every pop against it.
module tb_uart_rx_frontend;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYC    = 16 * CLK_DIV;

    logic       sysclk = 1'b0;
    logic       sysrst = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [2:0] rx_level;
    logic       frame_err;
    logic       overrun_err;
    logic       err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         tests = 0;
    int         errors = 0;
    int         fe_rises = 0;
    logic       fe_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_rx_frontend #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .RXD         (RXD),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_level    (rx_level),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .err_clr     (err_clr)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        RXD = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            RXD = d[i];
            wait_cyc(BIT_CYC);
        end
        RXD = stop_b;
        wait_cyc(BIT_CYC);
    endtask

    always @(negedge sysclk) begin
        if (sysrst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL pop_unexpected: got %02h, queue empty", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("pop_data", 32'(rx_data), 32'(exp_b));
            end
        end
        if (frame_err && !fe_prev) fe_rises++;
        fe_prev = frame_err;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests + 1, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        wait_cyc(3);
        @(negedge sysclk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_level", 32'(rx_level), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        sysrst = 1'b1;
        wait_cyc(10);

        // 0xA5: rx_valid rises 611 sysclk after the start edge is driven
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cyc(610);
                @(negedge sysclk);
                check("lat_before", 32'(rx_valid), 32'd0);
                wait_cyc(1);
                @(negedge sysclk);
                check("lat_after", 32'(rx_valid), 32'd1);
            end
        join
        wait_cyc(5);
        @(negedge sysclk);
        check("a5_level", 32'(rx_level), 32'd1);
        check("a5_frame_err", 32'(frame_err), 32'd0);
        check("a5_overrun_err", 32'(overrun_err), 32'd0);
        rx_ready = 1'b1;
        wait_cyc(3);
        rx_ready = 1'b0;
        @(negedge sysclk);
        check("a5_drained", 32'(rx_level), 32'd0);
        check("a5_q_empty", 32'(exp_q.size()), 32'd0);

        // False start: 20-cycle low glitch
        RXD = 1'b0;
        wait_cyc(20);
        RXD = 1'b1;
        wait_cyc(200);
        @(negedge sysclk);
        check("fs_valid", 32'(rx_valid), 32'd0);
        check("fs_frame_err", 32'(frame_err), 32'd0);

        // 0x3C with low stop bit, line held low: one frame error, nothing stored
        send_frame(8'h3C, 1'b0);
        wait_cyc(200);
        RXD = 1'b1;
        wait_cyc(50);
        @(negedge sysclk);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_rises", 32'(fe_rises), 32'd1);
        check("fe_level", 32'(rx_level), 32'd0);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        @(negedge sysclk);
        check("fe_cleared", 32'(frame_err), 32'd0);
        wait_cyc(100);
        @(negedge sysclk);
        check("fe_stays_clear", 32'(frame_err), 32'd0);

        // Overrun: five bytes into a four-entry FIFO with no consumer
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        wait_cyc(5);
        @(negedge sysclk);
        check("ovr_level", 32'(rx_level), 32'd4);
        check("ovr_flag", 32'(overrun_err), 32'd1);
        rx_ready = 1'b1;
        wait_cyc(10);
        rx_ready = 1'b0;
        @(negedge sysclk);
        check("ovr_drained", 32'(rx_level), 32'd0);
        check("ovr_q_empty", 32'(exp_q.size()), 32'd0);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        @(negedge sysclk);
        check("ovr_cleared", 32'(overrun_err), 32'd0);

        // Full FIFO with a pop in the same cycle as the fifth push
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        wait_cyc(5);
        @(negedge sysclk);
        check("full_level", 32'(rx_level), 32'd4);
        exp_q.push_back(8'h15);
        fork
            send_frame(8'h15, 1'b1);
            begin
                wait_cyc(610);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
                @(negedge sysclk);
                check("pp_level", 32'(rx_level), 32'd4);
                check("pp_overrun_err", 32'(overrun_err), 32'd0);
            end
        join
        rx_ready = 1'b1;
        wait_cyc(10);
        rx_ready = 1'b0;
        @(negedge sysclk);
        check("pp_q_empty", 32'(exp_q.size()), 32'd0);
        check("pp_drained", 32'(rx_level), 32'd0);

        // Reset in the middle of bit 3, with a byte already waiting
        send_frame(8'h77, 1'b1);
        wait_cyc(5);
        @(negedge sysclk);
        check("pre_rst_level", 32'(rx_level), 32'd1);
        RXD = 1'b0;
        wait_cyc(BIT_CYC * 4 + BIT_CYC / 2);
        sysrst = 1'b0;
        RXD = 1'b1;
        wait_cyc(1);
        sysrst = 1'b1;
        @(negedge sysclk);
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_data", 32'(rx_data), 32'd0);
        check("mrst_level", 32'(rx_level), 32'd0);
        check("mrst_frame_err", 32'(frame_err), 32'd0);
        check("mrst_overrun_err", 32'(overrun_err), 32'd0);
        wait_cyc(20);
        exp_q.push_back(8'h5A);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        wait_cyc(20);
        rx_ready = 1'b0;
        @(negedge sysclk);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
        check("post_rst_level", 32'(rx_level), 32'd0);
        check("post_rst_frame_err", 32'(frame_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Receive-side UART stage between the board RXD pin and the UART consumer inside cmsdk_mcu.
- Synchronises RXD into the sysclk domain.
- Recovers 8N1 frames with 16x oversampling.
- Buffers received bytes in a small FIFO with a valid/ready output.
- Reports sticky framing and overrun errors.
- Runs entirely on the PLL system clock.

Parameters:
CLK_DIV, 27, sysclk cycles per 16x oversample tick; legal range 1..65535; 27 gives 115200 baud at 50 MHz.
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.

Ports:
sysclk  input  1  system clock (PLL c0)
sysrst  input  1  synchronous active-low reset
RXD  input  1  asynchronous serial line, idle high
rx_data  output  8  byte at FIFO head
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts rx_data this cycle
rx_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_err  output  1  sticky: stop bit sampled low
overrun_err  output  1  sticky: byte dropped because FIFO full
err_clr  input  1  one-cycle pulse clears all sticky error flags

Behaviour:
- Reset: sysrst is sampled only on rising sysclk edges; low = reset.
  - Reset values: rx_data=0, rx_valid=0, rx_level=0, frame_err=0, overrun_err=0; FSM IDLE; tick counter 0; both synchroniser flops 1.
  - Reset asserted mid-frame abandons the frame; the partial byte is never written.
- Synchroniser: 2 flops; rxd_s is the second-flop output. The FSM sees RXD with 2 cycles of latency.
- Tick generator:
  - 16-bit counter counts 0..CLK_DIV-1; tick=1 when count==CLK_DIV-1, then count wraps to 0.
  - Counter is forced to 0 on the IDLE->START transition, so sample phase aligns to the start edge.
- Sample counter: 4-bit, incremented per tick, wraps 15->0. Mid-bit sample point is count==7.
- FSM states and transitions:
  - IDLE: rxd_s==0 -> START; clear sample counter.
  - START: at mid sample, rxd_s==0 -> DATA with bit index 0. rxd_s==1 is a false start -> IDLE, no error.
  - DATA: at each mid sample (every 16 ticks), shift rxd_s in LSB-first. After bit 7 -> STOP.
  - STOP: at mid sample, rxd_s==1 -> push byte, then IDLE. rxd_s==0 -> frame_err=1, byte discarded, then BREAK.
  - BREAK: wait for rxd_s==1, then IDLE. A held-low line produces exactly one frame_err.
- FIFO push and pop:
  - Push is a one-cycle strobe in the cycle the STOP mid sample is taken.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun_err=1; FIFO contents are unchanged.
  - Pop occurs when rx_valid && rx_ready. rx_data is the registered head, valid whenever rx_valid=1.
  - Push and pop in the same cycle leave rx_level unchanged.
  - Latency: rx_valid rises on the sysclk edge following the STOP mid-sample push into an empty FIFO.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Error flags:
  - err_clr clears both flags.
  - If err_clr coincides with a new error event, the set wins; the flag stays 1.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1: a PARITY state sits between DATA and STOP and samples at mid-bit.
  - Extra output parity_err (1 bit, sticky, reset 0, cleared by err_clr).
  - Set when XOR(data bits, parity bit) != 0; the byte is discarded and not pushed.
  - Set wins over clear, as for the other flags.
- Undefined: 8N1 only; the parity_err port and the PARITY state do not exist.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8.
- Sub-module uart_rx_fifo: parameterised synchronous FIFO with push/pop/full/empty/level and the same sysclk/sysrst convention.
- Top level holds synchroniser, tick generator and FSM.

Test Plan:
- CLK_DIV=4; send 0xA5 8N1 at 64 sysclk/bit -> rx_valid=1 the cycle after stop mid-sample; rx_data=0xA5; rx_level=1; no error flags.
- RXD low pulse of 20 sysclk then high -> false start, returns to IDLE; rx_valid stays 0, frame_err stays 0.
- Send 0x3C with stop bit driven low, RXD held low 200 cycles -> frame_err=1 exactly once, rx_level=0. Then err_clr pulse -> frame_err=0.
- rx_ready=0; send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> rx_level=4, overrun_err=1. Pops return 0x01,0x02,0x03,0x04 in order.
- FIFO full, rx_ready=1 held in the cycle of the 5th push -> push accepted, rx_level stays 4, overrun_err=0.
- sysrst low for 1 cycle midway through bit 3 of a frame -> all outputs at reset values; the next clean frame 0x5A is received correctly.
